// File: rtl/tick_meter_pkg.sv
// Shared definitions for the tick period meter.
//   meter_state_t : measurement FSM states
//   CLK_HZ        : nominal system clock frequency
//   EXP_HALF_1S   : clk cycles in one half of a 1 s period at CLK_HZ
package tick_meter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        MEAS_LOW_PRE,
        MEAS_HIGH,
        MEAS_LOW
    } meter_state_t;

    localparam int unsigned CLK_HZ      = 25000000;
    localparam int unsigned EXP_HALF_1S = CLK_HZ / 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a registered copy for edge detection.
// Both edges see the same latency, so intervals between pulses are exact.
//   clk   : system clock
//   reset : synchronous, active-low reset
//   d     : asynchronous input
//   rise  : one-cycle pulse after a synchronised 0->1 transition
//   fall  : one-cycle pulse after a synchronised 1->0 transition
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/tick_period_meter.sv
// Measures high and low phase lengths of a slow divided clock in clk cycles.
//   clk, reset  : system clock, synchronous active-low reset
//   en          : measurement enable (0 returns to IDLE, clears sticky flags)
//   sig_in      : asynchronous slow signal under test
//   high_cycles : last captured high-phase length
//   low_cycles  : last captured low-phase length
//   meas_valid  : one-cycle pulse when a full period has been captured
//   in_tol      : both phases of the last period within EXP_HALF +/- TOL
//   timeout     : sticky, no edge within 2*EXP_HALF cycles
//   sat         : sticky, phase counter reached all-ones
module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int unsigned EXP_HALF = EXP_HALF_1S,
    parameter int unsigned TOL      = 1000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] low_cycles,
    output logic             meas_valid,
    output logic             in_tol,
    output logic             timeout,
    output logic             sat
);

    // Limits are held 64 bits wide so a threshold larger than the counter
    // range simply never matches instead of wrapping.
    localparam logic [63:0] TOL_LO = 64'(EXP_HALF - TOL);
    localparam logic [63:0] TOL_HI = 64'(EXP_HALF + TOL);
    localparam logic [63:0] TO_LIM = 64'(2 * EXP_HALF);

    meter_state_t     state;
    meter_state_t     state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             rise;
    logic             fall;
    logic             edge_det;
    logic             at_lim;
    logic             cap_high;
    logic             cap_low;
    logic             to_hit;
    logic             high_ok;
    logic             low_ok;

    sync_edge_detect u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sig_in),
        .rise  (rise),
        .fall  (fall)
    );

    assign edge_det = rise | fall;
    // An edge in the same cycle as the threshold wins.
    assign at_lim   = (64'(cnt) == TO_LIM) && !edge_det;
    assign high_ok  = (64'(high_cycles) >= TOL_LO) && (64'(high_cycles) <= TOL_HI);
    assign low_ok   = (64'(cnt) >= TOL_LO) && (64'(cnt) <= TOL_HI);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cap_high   = 1'b0;
        cap_low    = 1'b0;
        to_hit     = 1'b0;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = ALIGN;
                ALIGN: begin
                    if (rise) begin
                        state_next = MEAS_HIGH;
                    end else if (fall) begin
                        state_next = MEAS_LOW_PRE;
                    end else if (at_lim) begin
                        to_hit = 1'b1;
                    end
                end
                MEAS_LOW_PRE: begin
                    if (rise) begin
                        state_next = MEAS_HIGH;
                    end else if (at_lim) begin
                        to_hit     = 1'b1;
                        state_next = ALIGN;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        cap_high   = 1'b1;
                        state_next = MEAS_LOW;
                    end else if (at_lim) begin
                        to_hit     = 1'b1;
                        state_next = ALIGN;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        cap_low    = 1'b1;
                        state_next = MEAS_HIGH;
                    end else if (at_lim) begin
                        to_hit     = 1'b1;
                        state_next = ALIGN;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Loading 1 on an edge makes the value seen at the next edge equal to
    // the exact number of cycles between the two edges.
    always_comb begin
        cnt_next = cnt;
        if (state == IDLE) begin
            cnt_next = '0;
        end else if (edge_det) begin
            cnt_next = CNT_W'(1);
        end else if (cnt != '1) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt         <= '0;
            high_cycles <= '0;
            low_cycles  <= '0;
            meas_valid  <= 1'b0;
            in_tol      <= 1'b0;
            timeout     <= 1'b0;
            sat         <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            meas_valid <= cap_low;
            if (cap_high) begin
                high_cycles <= cnt;
            end
            if (cap_low) begin
                low_cycles <= cnt;
                in_tol     <= high_ok && low_ok;
            end else if (to_hit) begin
                in_tol <= 1'b0;
            end
            if (!en) begin
                timeout <= 1'b0;
                sat     <= 1'b0;
            end else begin
                if (to_hit) begin
                    timeout <= 1'b1;
                end
                if ((state != IDLE) && (cnt_next == '1)) begin
                    sat <= 1'b1;
                end
            end
        end
    end

endmodule
